// File: rtl/sata_phy_pkg.sv
// Shared state encodings and default timing constants for the SATA link supervisor
// and its timer.
package sata_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PHY_RST   = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_LINK_UP   = 3'd3,
    ST_SPEED_CHG = 3'd4
  } sup_state_e;

  localparam int TIMER_W          = 24;
  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LINK_TIMEOUT = 24'hC0000;
  localparam int DEF_MAX_TRIES    = 4;
  localparam int DEF_LOSS_FILTER  = 8;

  // The timer is loaded on entry and signals done while showing zero, so a
  // window of N cycles needs a preset of N-1.
  function automatic logic [TIMER_W-1:0] tmr_preset(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sata_sup_timer.sv
// Loadable 24-bit down-counter; done is high whenever the count has reached zero.
module sata_sup_timer
  import sata_phy_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic               dec,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/sata_link_supervisor.sv
// SATA link bring-up supervisor: OOB reset pacing, link timeout retries, speed
// fallback and link-loss filtering. Optional Gen1 fallback: SATA_GEN1_FALLBACK_EN.
module sata_link_supervisor
  import sata_phy_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LINK_TIMEOUT = DEF_LINK_TIMEOUT,
  parameter int MAX_TRIES    = DEF_MAX_TRIES,
  parameter int LOSS_FILTER  = DEF_LOSS_FILTER
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       host_link_reset,
  input  logic       rx_locked,
  input  logic       linkup,
  output logic       oob_reset,
  output logic       gen2,
  output logic       link_ok,
  output logic [3:0] retry_cnt,
  output logic       fail_pulse,
  output logic [2:0] state_out
);

  localparam logic [3:0]         MAX_T       = 4'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] RST_PRESET  = tmr_preset(RST_CYCLES);
  localparam logic [TIMER_W-1:0] LINK_PRESET = tmr_preset(LINK_TIMEOUT);
  localparam logic [TIMER_W-1:0] LOSS_PRESET = tmr_preset(LOSS_FILTER);

  sup_state_e         state_reg;
  logic               tmr_clear;
  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_done;
  logic [TIMER_W-1:0] tmr_val;
  logic [3:0]         retry_inc;

  assign retry_inc = (retry_cnt >= MAX_T) ? MAX_T : retry_cnt + 4'd1;
  assign state_out = state_reg;

  // One timer is reused: reset window, link timeout, and the loss filter,
  // which is reloaded on every linkup-high cycle so only a consecutive run expires.
  always_comb begin
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = '0;
    if (host_link_reset) begin
      tmr_clear = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rx_locked) begin
            tmr_load = 1'b1;
            tmr_val  = RST_PRESET;
          end else begin
            tmr_clear = 1'b1;
          end
        end
        ST_PHY_RST: begin
          if (!rx_locked) begin
            tmr_clear = 1'b1;
          end else if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = LINK_PRESET;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_WAIT_LINK: begin
          if (!rx_locked) begin
            tmr_clear = 1'b1;
          end else if (linkup) begin
            tmr_load = 1'b1;
            tmr_val  = LOSS_PRESET;
          end else if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = RST_PRESET;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_LINK_UP: begin
          if (linkup) begin
            tmr_load = 1'b1;
            tmr_val  = LOSS_PRESET;
          end else if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = RST_PRESET;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_SPEED_CHG: begin
          if (!rx_locked) begin
            tmr_clear = 1'b1;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = RST_PRESET;
          end
        end
        default: tmr_clear = 1'b1;
      endcase
    end
  end

  sata_sup_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      oob_reset  <= 1'b1;
      gen2       <= 1'b1;
      link_ok    <= 1'b0;
      retry_cnt  <= 4'd0;
      fail_pulse <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      if (host_link_reset) begin
        state_reg <= ST_IDLE;
        oob_reset <= 1'b1;
        gen2      <= 1'b1;
        link_ok   <= 1'b0;
        retry_cnt <= 4'd0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            oob_reset <= 1'b1;
            if (rx_locked) state_reg <= ST_PHY_RST;
          end
          ST_PHY_RST: begin
            if (!rx_locked) begin
              state_reg <= ST_IDLE;
            end else if (tmr_done) begin
              state_reg <= ST_WAIT_LINK;
              oob_reset <= 1'b0;
            end
          end
          ST_WAIT_LINK: begin
            if (!rx_locked) begin
              state_reg <= ST_IDLE;
              oob_reset <= 1'b1;
            end else if (linkup) begin
              state_reg <= ST_LINK_UP;
              link_ok   <= 1'b1;
              retry_cnt <= 4'd0;
            end else if (tmr_done) begin
              oob_reset <= 1'b1;
              if (retry_inc == MAX_T) begin
`ifdef SATA_GEN1_FALLBACK_EN
                state_reg <= ST_SPEED_CHG;
                retry_cnt <= retry_inc;
`else
                state_reg  <= ST_PHY_RST;
                retry_cnt  <= 4'd0;
                fail_pulse <= 1'b1;
`endif
              end else begin
                state_reg <= ST_PHY_RST;
                retry_cnt <= retry_inc;
              end
            end
          end
          ST_LINK_UP: begin
            if (!linkup && tmr_done) begin
              state_reg <= ST_PHY_RST;
              oob_reset <= 1'b1;
              link_ok   <= 1'b0;
              gen2      <= 1'b1;
              retry_cnt <= 4'd0;
            end
          end
`ifdef SATA_GEN1_FALLBACK_EN
          ST_SPEED_CHG: begin
            oob_reset <= 1'b1;
            if (!rx_locked) begin
              state_reg <= ST_IDLE;
            end else begin
              // Returning to Gen2 from Gen1 means every speed has been tried.
              state_reg  <= ST_PHY_RST;
              gen2       <= ~gen2;
              retry_cnt  <= 4'd0;
              fail_pulse <= ~gen2;
            end
          end
`endif
          default: begin
            state_reg <= ST_IDLE;
            oob_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sata_link_supervisor.sv
// Directed self-checking bench for sata_link_supervisor with short timing parameters.
module tb_sata_link_supervisor;

  localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_WAIT = 3'd2, S_UP = 3'd3, S_SPD = 3'd4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       host_link_reset = 1'b0;
  logic       rx_locked = 1'b0;
  logic       linkup = 1'b0;
  logic       oob_reset, gen2, link_ok, fail_pulse;
  logic [3:0] retry_cnt;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;
  int fail_seen = 0;
  int gen1_seen = 0;

  always #5 clk = ~clk;

  sata_link_supervisor #(
    .RST_CYCLES(4), .LINK_TIMEOUT(100), .MAX_TRIES(2), .LOSS_FILTER(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .host_link_reset(host_link_reset),
    .rx_locked(rx_locked), .linkup(linkup), .oob_reset(oob_reset),
    .gen2(gen2), .link_ok(link_ok), .retry_cnt(retry_cnt),
    .fail_pulse(fail_pulse), .state_out(state_out)
  );

  // Values read at the posedge are the ones held through the previous cycle.
  always @(posedge clk) begin
    if (reset_n === 1'b1 && fail_pulse === 1'b1) fail_seen++;
    if (reset_n === 1'b1 && gen2 !== 1'b1) gen1_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for_state(input logic [2:0] s, output int cyc);
    cyc = 0;
    while (state_out !== s && cyc <= 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (state_out !== s) begin
      errors++;
      $display("FAIL wait_for_state: state %0d never reached, still %0d", s, state_out);
      cyc = -1;
    end
  endtask

  task automatic wait_leave(input logic [2:0] s, output int cyc);
    cyc = 0;
    while (state_out === s && cyc <= 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (state_out === s) begin
      errors++;
      $display("FAIL wait_leave: stuck in state %0d", s);
      cyc = -1;
    end
  endtask

  task automatic test_reset();
    rx_locked = 1'b0;
    #1 reset_n = 1'b0;
    tick(2);
    checks++; if (state_out !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    checks++; if (oob_reset !== 1'b1) begin errors++; $display("FAIL reset_oob: got %b expected 1", oob_reset); end
    checks++; if (gen2 !== 1'b1) begin errors++; $display("FAIL reset_gen2: got %b expected 1", gen2); end
    checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL reset_link_ok: got %b expected 0", link_ok); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
    checks++; if (fail_pulse !== 1'b0) begin errors++; $display("FAIL reset_fail_pulse: got %b expected 0", fail_pulse); end
    $display("test_reset: done");
  endtask

  task automatic test_linkup();
    int c;
    rx_locked = 1'b1;
    reset_n = 1'b1;
    wait_for_state(S_RST, c);
    checks++; if (c !== 1) begin errors++; $display("FAIL idle_to_phy_rst: got %0d cycles expected 1", c); end
    wait_for_state(S_WAIT, c);
    checks++; if (c !== 4) begin errors++; $display("FAIL phy_rst_len: got %0d cycles expected 4", c); end
    checks++; if (oob_reset !== 1'b0) begin errors++; $display("FAIL wait_oob: got %b expected 0", oob_reset); end
    tick(50);
    checks++; if (link_ok !== 1'b0 || state_out !== S_WAIT) begin errors++; $display("FAIL pre_linkup: link_ok %b state %0d expected 0/2", link_ok, state_out); end
    linkup = 1'b1;
    tick(1);
    checks++; if (state_out !== S_UP) begin errors++; $display("FAIL linkup_state: got %0d expected 3", state_out); end
    checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL linkup_link_ok: got %b expected 1", link_ok); end
    checks++; if (gen2 !== 1'b1 || retry_cnt !== 4'd0) begin errors++; $display("FAIL linkup_gen2_retry: got %b/%0d expected 1/0", gen2, retry_cnt); end
    $display("test_linkup: link up after 50 cycles in WAIT_LINK");
  endtask

  task automatic test_loss_filter();
    linkup = 1'b0;
    tick(2);
    checks++; if (link_ok !== 1'b1 || state_out !== S_UP) begin errors++; $display("FAIL glitch2_low: link_ok %b state %0d expected 1/3", link_ok, state_out); end
    linkup = 1'b1;
    tick(2);
    checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL glitch2_recover: got %b expected 1", link_ok); end
    linkup = 1'b0;
    tick(2);
    checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL loss_2of3: got %b expected 1", link_ok); end
    tick(1);
    checks++; if (state_out !== S_RST || link_ok !== 1'b0) begin errors++; $display("FAIL loss_3of3: state %0d link_ok %b expected 1/0", state_out, link_ok); end
    checks++; if (oob_reset !== 1'b1 || gen2 !== 1'b1 || retry_cnt !== 4'd0) begin errors++; $display("FAIL loss_outputs: oob %b gen2 %b retry %0d expected 1/1/0", oob_reset, gen2, retry_cnt); end
    $display("test_loss_filter: 2-cycle glitch filtered, 3-cycle loss detected");
  endtask

  task automatic test_retry_rxlock();
    int c;
    wait_for_state(S_WAIT, c);
    wait_leave(S_WAIT, c);
    checks++; if (c !== 100) begin errors++; $display("FAIL timeout_len: got %0d cycles expected 100", c); end
    checks++; if (state_out !== S_RST || retry_cnt !== 4'd1) begin errors++; $display("FAIL timeout_retry: state %0d retry %0d expected 1/1", state_out, retry_cnt); end
    wait_for_state(S_WAIT, c);
    tick(10);
    rx_locked = 1'b0;
    tick(1);
    checks++; if (state_out !== S_IDLE || retry_cnt !== 4'd1 || oob_reset !== 1'b1) begin errors++; $display("FAIL rx_unlock: state %0d retry %0d oob %b expected 0/1/1", state_out, retry_cnt, oob_reset); end
    rx_locked = 1'b1;
    $display("test_retry_rxlock: retry after timeout, unlock returns to IDLE");
  endtask

  task automatic test_host_reset();
    int c;
    int f0;
    wait_for_state(S_WAIT, c);
    tick(99);
    checks++; if (state_out !== S_WAIT || retry_cnt !== 4'd1) begin errors++; $display("FAIL pre_timeout: state %0d retry %0d expected 2/1", state_out, retry_cnt); end
    f0 = fail_seen;
    host_link_reset = 1'b1;
    tick(1);
    checks++; if (state_out !== S_IDLE) begin errors++; $display("FAIL host_rst_state: got %0d expected 0", state_out); end
    checks++; if (retry_cnt !== 4'd0 || fail_pulse !== 1'b0) begin errors++; $display("FAIL host_rst_retry_fail: retry %0d fail %b expected 0/0", retry_cnt, fail_pulse); end
    checks++; if (oob_reset !== 1'b1 || gen2 !== 1'b1 || link_ok !== 1'b0) begin errors++; $display("FAIL host_rst_outputs: oob %b gen2 %b link_ok %b expected 1/1/0", oob_reset, gen2, link_ok); end
    tick(1);
    checks++; if (state_out !== S_IDLE) begin errors++; $display("FAIL host_rst_hold: got %0d expected 0", state_out); end
    host_link_reset = 1'b0;
    tick(1);
    checks++; if (fail_seen !== f0) begin errors++; $display("FAIL host_rst_no_pulse: got %0d pulses expected 0", fail_seen - f0); end
    checks++; if (state_out !== S_RST) begin errors++; $display("FAIL host_rst_release: got %0d expected 1", state_out); end
    $display("test_host_reset: host reset dominates simultaneous timeout");
  endtask

`ifdef SATA_GEN1_FALLBACK_EN
  task automatic test_fallback();
    int c;
    int f0;
    logic exp_gen;
    f0 = fail_seen;
    exp_gen = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      wait_for_state(S_WAIT, c);
      wait_leave(S_WAIT, c);
      if (t % 2 == 1) begin
        checks++; if (state_out !== S_RST || retry_cnt !== 4'd1 || gen2 !== exp_gen) begin errors++; $display("FAIL fb_retry t%0d: state %0d retry %0d gen2 %b expected 1/1/%b", t, state_out, retry_cnt, gen2, exp_gen); end
      end else begin
        checks++; if (state_out !== S_SPD || retry_cnt !== 4'd2 || oob_reset !== 1'b1) begin errors++; $display("FAIL fb_speed_chg t%0d: state %0d retry %0d oob %b expected 4/2/1", t, state_out, retry_cnt, oob_reset); end
        tick(1);
        exp_gen = ~exp_gen;
        checks++; if (state_out !== S_RST || gen2 !== exp_gen || retry_cnt !== 4'd0) begin errors++; $display("FAIL fb_toggle t%0d: state %0d gen2 %b retry %0d expected 1/%b/0", t, state_out, gen2, retry_cnt, exp_gen); end
        checks++; if (fail_pulse !== (t == 4)) begin errors++; $display("FAIL fb_fail_pulse t%0d: got %b expected %b", t, fail_pulse, (t == 4)); end
      end
    end
    tick(1);
    checks++; if (fail_seen - f0 !== 1) begin errors++; $display("FAIL fb_pulse_count: got %0d expected 1", fail_seen - f0); end
    $display("test_fallback: Gen2 -> Gen1 -> Gen2 with one fail pulse");
  endtask
`else
  task automatic test_no_fallback();
    int c;
    int f0;
    int g0;
    f0 = fail_seen;
    g0 = gen1_seen;
    for (int t = 1; t <= 4; t++) begin
      wait_for_state(S_WAIT, c);
      wait_leave(S_WAIT, c);
      checks++; if (c !== 100 || state_out !== S_RST) begin errors++; $display("FAIL nfb_timeout t%0d: %0d cycles state %0d expected 100/1", t, c, state_out); end
      checks++; if (retry_cnt !== 4'(t % 2) || fail_pulse !== (t % 2 == 0)) begin errors++; $display("FAIL nfb_retry t%0d: retry %0d fail %b expected %0d/%b", t, retry_cnt, fail_pulse, t % 2, (t % 2 == 0)); end
      tick(1);
      checks++; if (fail_pulse !== 1'b0) begin errors++; $display("FAIL nfb_pulse_width t%0d: got %b expected 0", t, fail_pulse); end
    end
    checks++; if (fail_seen - f0 !== 2) begin errors++; $display("FAIL nfb_pulse_count: got %0d expected 2", fail_seen - f0); end
    checks++; if (gen1_seen !== g0) begin errors++; $display("FAIL nfb_gen2_const: gen2 low for %0d cycles expected 0", gen1_seen - g0); end
    $display("test_no_fallback: fail pulse every 2 timeouts, gen2 held");
  endtask
`endif

  task automatic test_async_reset();
    int c;
`ifdef SATA_GEN1_FALLBACK_EN
    repeat (2) begin
      wait_for_state(S_WAIT, c);
      wait_leave(S_WAIT, c);
    end
    wait_for_state(S_WAIT, c);
    tick(10);
    checks++; if (gen2 !== 1'b0) begin errors++; $display("FAIL async_pre: gen2 %b expected 0", gen2); end
`else
    wait_for_state(S_WAIT, c);
    wait_leave(S_WAIT, c);
    wait_for_state(S_WAIT, c);
    tick(10);
    checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL async_pre: retry %0d expected 1", retry_cnt); end
`endif
    #2 reset_n = 1'b0;
    #1;
    checks++; if (state_out !== S_IDLE || oob_reset !== 1'b1) begin errors++; $display("FAIL async_state_oob: state %0d oob %b expected 0/1", state_out, oob_reset); end
    checks++; if (gen2 !== 1'b1 || link_ok !== 1'b0) begin errors++; $display("FAIL async_gen2_link: gen2 %b link_ok %b expected 1/0", gen2, link_ok); end
    checks++; if (retry_cnt !== 4'd0 || fail_pulse !== 1'b0) begin errors++; $display("FAIL async_retry_fail: retry %0d fail %b expected 0/0", retry_cnt, fail_pulse); end
    tick(1);
    reset_n = 1'b1;
    #1;
    checks++; if (state_out !== S_IDLE) begin errors++; $display("FAIL release_hold: got %0d expected 0", state_out); end
    tick(1);
    checks++; if (state_out !== S_RST) begin errors++; $display("FAIL release_first_edge: got %0d expected 1", state_out); end
    $display("test_async_reset: outputs reset without a clock edge");
  endtask

  initial begin
    test_reset();
    test_linkup();
    test_loss_filter();
    test_retry_rxlock();
    test_host_reset();
`ifdef SATA_GEN1_FALLBACK_EN
    test_fallback();
`else
    test_no_fallback();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sata_link_supervisor.md
SATA_LINK_SUPERVISOR -- requirements
Module: sata_link_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles oob_reset is held high per attempt.
REQ-002 SHALL have parameter LINK_TIMEOUT, default 24'hC0000: cycles allowed for linkup after oob_reset drops.
REQ-003 SHALL have parameter MAX_TRIES, default 4: failed attempts per speed before a speed change.
REQ-004 SHALL have parameter LOSS_FILTER, default 8: consecutive linkup-low cycles that count as link loss.
REQ-005 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port host_link_reset  input  1  host request to restart negotiation (level, sampled each cycle).
REQ-008 SHALL have port rx_locked  input  1  transceiver PLL locked.
REQ-009 SHALL have port linkup  input  1  link-established indication from the OOB sequencer.
REQ-010 SHALL have port oob_reset  output  1  active-high reset to the OOB sequencer.
REQ-011 SHALL have port gen2  output  1  selected speed, 1 = 3.0 Gb/s, 0 = 1.5 Gb/s.
REQ-012 SHALL have port link_ok  output  1  link up and stable.
REQ-013 SHALL have port retry_cnt  output  4  failed attempts at current speed.
REQ-014 SHALL have port fail_pulse  output  1  one-cycle pulse when all speeds exhausted.
REQ-015 SHALL have port state_out  output  3  current state encoding for debug.

Function
REQ-016 SHALL implement states IDLE=0, PHY_RST=1, WAIT_LINK=2, LINK_UP=3, SPEED_CHG=4; all outputs registered.
REQ-017 IDLE: oob_reset=1; go PHY_RST when rx_locked=1 and host_link_reset=0.
REQ-018 PHY_RST: oob_reset=1 for exactly RST_CYCLES cycles, then WAIT_LINK with oob_reset=0 on the following cycle.
REQ-019 WAIT_LINK: linkup=1 -> LINK_UP with link_ok=1 next cycle and retry_cnt cleared; timer reaching LINK_TIMEOUT-1 with no linkup -> retry_cnt+1 and PHY_RST, or SPEED_CHG if incremented retry_cnt equals MAX_TRIES.
REQ-020 SPEED_CHG: toggle gen2, clear retry_cnt, hold oob_reset=1 for one cycle, then PHY_RST; when toggling gen2 0->1 (all speeds exhausted) assert fail_pulse for that one cycle.
REQ-021 LINK_UP: count consecutive linkup=0 cycles; at LOSS_FILTER -> link_ok=0, gen2=1, retry_cnt=0, PHY_RST; any linkup=1 clears the loss counter.
REQ-022 host_link_reset=1 in any state SHALL force IDLE next cycle with link_ok=0, gen2=1, retry_cnt=0, timers cleared; it dominates all simultaneous events.
REQ-023 rx_locked=0 in PHY_RST, WAIT_LINK or SPEED_CHG SHALL return to IDLE without incrementing retry_cnt; in LINK_UP it is ignored (loss filter governs).
REQ-024 Timeout and linkup on the same cycle in WAIT_LINK SHALL resolve as linkup.
REQ-025 retry_cnt SHALL saturate at MAX_TRIES and never wrap; timer width SHALL be 24 bits.

Reset
REQ-026 On reset_n=0: state IDLE, oob_reset=1, gen2=1, link_ok=0, retry_cnt=0, fail_pulse=0, all timers 0.
REQ-027 Reset deassertion SHALL take effect on the first clk edge after reset_n rises; no synchroniser inside the block.

Configuration
REQ-028 Macro SATA_GEN1_FALLBACK_EN defined: SPEED_CHG behaviour as REQ-020.
REQ-029 Macro undefined: gen2 tied 1, SPEED_CHG never entered; at retry_cnt==MAX_TRIES assert fail_pulse one cycle, clear retry_cnt, go PHY_RST.

Structure
REQ-030 State encodings and default timing constants SHALL live in shared package sata_phy_pkg.
REQ-031 A sub-module sata_sup_timer (loadable 24-bit down-counter with done flag) SHALL serve PHY_RST, WAIT_LINK and loss-filter timing.

Verification (RST_CYCLES=4, LINK_TIMEOUT=100, MAX_TRIES=2, LOSS_FILTER=3)
REQ-032 rx_locked=1, linkup rises 50 cycles into WAIT_LINK -> link_ok=1 next cycle, gen2=1, retry_cnt=0.
REQ-033 linkup never rises (fallback on) -> two timeouts at gen2, gen2=0, two at gen1, fail_pulse once, gen2=1.
REQ-034 In LINK_UP, linkup low 2 cycles then high -> link_ok stays 1; low 3 cycles -> link_ok=0, PHY_RST entered.
REQ-035 host_link_reset=1 during WAIT_LINK with timeout same cycle -> IDLE, retry_cnt unchanged-to-0, no fail_pulse.
REQ-036 reset_n pulsed low mid-WAIT_LINK at gen2=0 -> all outputs per REQ-026 immediately (asynchronous).
REQ-037 Fallback off, no linkup -> fail_pulse every 2 timeouts, gen2 constantly 1.
